decoder_sel_sequencer: RTL and testbench

Programmable select sequencer that sits directly upstream of the 3-to-8 decoder. It drives that decoder's three select inputs (`a` = LSB, `b`, `c` = MSB) from a registered 3-bit index. The index advances once every `DIV` enabled clocks in up, down or (optionally) bounce order, which produces a rotating one-hot pattern on y0..y7. A synchronous load is provided, plus step and wrap strobes for downstream status logic.

---
 rtl/decoder_sel_sequencer.sv | 142 ++++++++++++++
 tb/tb_decoder_sel_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_sel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : decoder_sel_sequencer
//  Purpose  : Drives the a/b/c select inputs of a 3-to-8 decoder from a
//             registered 3-bit index that steps every DIV enabled clocks in
//             up, down, hold or (optionally) bounce order. Provides a
//             synchronous load plus tick/wrap strobes.
//  Options  : DEC_SEL_BOUNCE_EN - when defined, mode 2'b10 bounces 0..7..0
//             using a direction flag; otherwise mode 2'b10 counts up.
//  Revision : 1.0 - initial release
// ============================================================================
module decoder_sel_sequencer #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       load,
    input  logic [2:0] load_val,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       tick,
    output logic       wrap
);

    localparam int         CNT_W       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [1:0] c_mode_up   = 2'b00;
    localparam logic [1:0] c_mode_down = 2'b01;
    localparam logic [1:0] c_mode_bnc  = 2'b10;

    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic             r_tick;
    logic             r_wrap;
    logic             w_step;
    logic [2:0]       w_idx_nxt;
    logic             w_wrap_nxt;
`ifdef DEC_SEL_BOUNCE_EN
    logic             r_dn;
    logic             w_dn_nxt;
`endif

    // A step fires on the enabled edge that completes a prescaler period.
    assign w_step = en && (r_cnt == CNT_W'(DIV - 1));

    // Next index, wrap flag and bounce direction for a step in the current mode.
    always_comb begin
        w_idx_nxt  = r_idx;
        w_wrap_nxt = 1'b0;
`ifdef DEC_SEL_BOUNCE_EN
        w_dn_nxt   = 1'b0;
`endif
        case (mode)
            c_mode_up: begin
                w_idx_nxt  = r_idx + 3'd1;
                w_wrap_nxt = (r_idx == 3'd7);
            end
            c_mode_down: begin
                w_idx_nxt  = r_idx - 3'd1;
                w_wrap_nxt = (r_idx == 3'd0);
            end
            c_mode_bnc: begin
`ifdef DEC_SEL_BOUNCE_EN
                if (!r_dn) begin
                    if (r_idx == 3'd7) begin
                        w_idx_nxt  = 3'd6;
                        w_dn_nxt   = 1'b1;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_idx_nxt  = r_idx + 3'd1;
                    end
                end else begin
                    if (r_idx == 3'd0) begin
                        w_idx_nxt  = 3'd1;
                        w_dn_nxt   = 1'b0;
                        w_wrap_nxt = 1'b1;
                    end else begin
                        w_idx_nxt  = r_idx - 3'd1;
                        w_dn_nxt   = 1'b1;
                    end
                end
`else
                w_idx_nxt  = r_idx + 3'd1;
                w_wrap_nxt = (r_idx == 3'd7);
`endif
            end
            default: begin
                w_idx_nxt  = r_idx;
                w_wrap_nxt = 1'b0;
            end
        endcase
    end

    // Prescaler, index and strobes; load overrides any step on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_idx  <= 3'd0;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (load) begin
            r_cnt  <= '0;
            r_idx  <= load_val;
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end else if (w_step) begin
            r_cnt  <= '0;
            r_idx  <= w_idx_nxt;
            r_tick <= 1'b1;
            r_wrap <= w_wrap_nxt;
        end else begin
            if (en) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_tick <= 1'b0;
            r_wrap <= 1'b0;
        end
    end

`ifdef DEC_SEL_BOUNCE_EN
    // Bounce direction; cleared by load and by any step outside bounce mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dn <= 1'b0;
        end else if (load) begin
            r_dn <= 1'b0;
        end else if (w_step) begin
            r_dn <= w_dn_nxt;
        end
    end
`endif

    assign a    = r_idx[0];
    assign b    = r_idx[1];
    assign c    = r_idx[2];
    assign tick = r_tick;
    assign wrap = r_wrap;

endmodule
`default_nettype wire

// File: tb/tb_decoder_sel_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_decoder_sel_sequencer
//  Purpose  : Self-checking bench for decoder_sel_sequencer. Three instances
//             (DIV = 1, 3, 4) share one stimulus stream and are compared
//             every cycle against a behavioural model. Honours
//             DEC_SEL_BOUNCE_EN the same way as the design.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_sel_sequencer;

    localparam int NI = 3;
    localparam int c_div [NI] = '{1, 3, 4};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [1:0]    mode;
    logic          load;
    logic [2:0]    load_val;
    logic [NI-1:0] a_v, b_v, c_v, tick_v, wrap_v;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state per instance; direction held as +1 / -1.
    int m_idx  [NI];
    int m_cnt  [NI];
    int m_dir  [NI];
    int m_tick [NI];
    int m_wrap [NI];

    always #5 clk = ~clk;

    decoder_sel_sequencer #(.DIV(1)) u_dut_d1 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .load_val(load_val),
        .a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .tick(tick_v[0]), .wrap(wrap_v[0]));
    decoder_sel_sequencer #(.DIV(3)) u_dut_d3 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .load_val(load_val),
        .a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .tick(tick_v[1]), .wrap(wrap_v[1]));
    decoder_sel_sequencer #(.DIV(4)) u_dut_d4 (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .load_val(load_val),
        .a(a_v[2]), .b(b_v[2]), .c(c_v[2]), .tick(tick_v[2]), .wrap(wrap_v[2]));

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NI; k++) begin
            m_idx[k] = 0; m_cnt[k] = 0; m_dir[k] = 1; m_tick[k] = 0; m_wrap[k] = 0;
        end
    endtask

    // One index step for instance k under the current mode.
    task automatic model_step(input int k);
        int n;
        m_tick[k] = 1;
        m_wrap[k] = 0;
        if (mode == 2'b11) begin
            m_dir[k] = 1;
        end else if (mode == 2'b01) begin
            n = m_idx[k] - 1;
            m_wrap[k] = (n < 0) ? 1 : 0;
            m_idx[k] = (n + 8) % 8;
            m_dir[k] = 1;
        end else begin
`ifdef DEC_SEL_BOUNCE_EN
            if (mode == 2'b10) begin
                // Move in the current direction; reflect off either end.
                n = m_idx[k] + m_dir[k];
                if (n < 0 || n > 7) begin
                    m_idx[k] = m_idx[k] - m_dir[k];
                    m_dir[k] = -m_dir[k];
                    m_wrap[k] = 1;
                end else begin
                    m_idx[k] = n;
                end
                return;
            end
`endif
            n = m_idx[k] + 1;
            m_wrap[k] = (n > 7) ? 1 : 0;
            m_idx[k] = n % 8;
            m_dir[k] = 1;
        end
    endtask

    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        for (int k = 0; k < NI; k++) begin
            m_tick[k] = 0;
            m_wrap[k] = 0;
            if (load) begin
                m_idx[k] = int'(load_val);
                m_cnt[k] = 0;
                m_dir[k] = 1;
            end else if (en) begin
                if (m_cnt[k] == c_div[k] - 1) begin
                    m_cnt[k] = 0;
                    model_step(k);
                end else begin
                    m_cnt[k]++;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NI; k++) begin
            check($sformatf("idx_div%0d", c_div[k]), int'({c_v[k], b_v[k], a_v[k]}), m_idx[k]);
            check($sformatf("tick_div%0d", c_div[k]), int'(tick_v[k]), m_tick[k]);
            check($sformatf("wrap_div%0d", c_div[k]), int'(wrap_v[k]), m_wrap[k]);
        end
    endtask

    // Advance one clock: model follows the edge, outputs are compared at the falling edge.
    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            model_edge();
            @(negedge clk);
            check_all();
        end
    endtask

    task automatic do_load(input logic [2:0] v);
        load = 1'b1; load_val = v;
        cyc(1);
        load = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1; en = 1'b1; mode = 2'b00; load = 1'b0; load_val = 3'd0;
        model_reset();
        #2 rst_n = 1'b0;

        // Reset held for three clocks with enable high.
        cyc(3);
        check("reset_abc_div4", int'({c_v[2], b_v[2], a_v[2]}), 0);
        check("reset_tick_div4", int'(tick_v[2]), 0);

        // Release: DIV=4 instance steps to 001 on the fourth enabled edge.
        rst_n = 1'b1;
        cyc(3);
        check("pre_step_div4", int'({c_v[2], b_v[2], a_v[2]}), 0);
        cyc(1);
        check("first_step_div4", int'({c_v[2], b_v[2], a_v[2]}), 1);
        check("first_tick_div4", int'(tick_v[2]), 1);
        cyc(2);

        // Up with wrap 7 -> 0.
        mode = 2'b00;
        do_load(3'b110);
        cyc(2);
        check("up_wrap_div1", int'(wrap_v[0]), 1);
        check("up_wrap_idx_div1", int'({c_v[0], b_v[0], a_v[0]}), 0);
        cyc(8);

        // Down with enable gated mid-count.
        mode = 2'b01;
        do_load(3'b001);
        cyc(2);
        en = 1'b0;
        cyc(5);
        en = 1'b1;
        cyc(12);

        // Bounce (or up, when the option is absent).
        mode = 2'b10;
        do_load(3'b101);
        cyc(3);
        check("bounce_turn_wrap_div1", int'(wrap_v[0]), 1);
`ifdef DEC_SEL_BOUNCE_EN
        check("bounce_turn_idx_div1", int'({c_v[0], b_v[0], a_v[0]}), 6);
`else
        check("bounce_turn_idx_div1", int'({c_v[0], b_v[0], a_v[0]}), 0);
`endif
        cyc(20);

        // Load colliding with a step on the DIV=4 instance.
        mode = 2'b00;
        do_load(3'b000);
        cyc(3);
        do_load(3'b011);
        check("collide_idx_div4", int'({c_v[2], b_v[2], a_v[2]}), 3);
        check("collide_tick_div4", int'(tick_v[2]), 0);
        cyc(4);
        check("after_collide_div4", int'({c_v[2], b_v[2], a_v[2]}), 4);

        // Randomised traffic including mid-cycle asynchronous resets.
        for (int i = 0; i < 1500; i++) begin
            en = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
            load = ($urandom_range(0, 19) == 0);
            load_val = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 149) == 0) begin
                rst_n = 1'b0;
                model_reset();
                #1;
                check_all();
                cyc(1);
                rst_n = 1'b1;
            end
            cyc(1);
        end
        load = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
